// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared constants and types for the key event queue
// Register word addresses, register bit positions, key code width and
// the capture-gating state type used by key_event_queue and key_fifo.
package key_pkg;

    localparam int KEY_W = 4;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;

    localparam int BIT_VALID    = 8;
    localparam int BIT_EMPTY    = 16;
    localparam int BIT_FULL     = 17;
    localparam int BIT_OVERFLOW = 18;
    localparam int BIT_CAPTURE  = 0;
    localparam int BIT_IRQ_EN   = 1;
    localparam int BIT_FLUSH    = 2;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } ctrl_state_t;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - synchronous key-code FIFO with flush and drop-on-full
// Ports: Clk/Rst (sync, active-high); push/push_data write side; pop read
// side (ignored when empty); flush empties the queue and beats a push;
// head is the oldest entry; full/empty/count status; drop flags a push
// rejected because the queue was full and nothing left that cycle.
module key_fifo
    import key_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [KEY_W-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [KEY_W-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             drop
);

    logic [KEY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop in the same cycle frees a slot, so a push at full still fits.
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop & ~flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge Clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - keypad event FIFO behind an Avalon-MM slave
// Ports: Clk/Rst (sync, active-high); key_flag/key_value from the keypad
// scanner (value valid the cycle after the flag); avs_* Avalon-MM slave
// with read latency 1; irq level interrupt.
module key_event_queue
    import key_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             key_flag,
    input  logic [KEY_W-1:0] key_value,
    input  logic [1:0]       avs_address,
    input  logic             avs_read,
    input  logic             avs_write,
    input  logic [31:0]      avs_writedata,
    output logic [31:0]      avs_readdata,
    output logic             irq
);

    ctrl_state_t      state;
    logic             flag_d;
    logic             irq_en;
    logic             overflow;
    logic             capture_en;
    logic             push;
    logic             pop;
    logic             flush;
    logic             wr_status;
    logic             wr_ctrl;
    logic [KEY_W-1:0] head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             drop;
    logic [31:0]      rd_word;
    logic             unused_wdata;

    assign unused_wdata = ^{avs_writedata[31:19], avs_writedata[17:3]};

    assign capture_en = (state == ST_RUN);
    // The scanner presents key_value one cycle after its flag, so the push
    // is keyed off the delayed flag and takes the value live that cycle.
    assign push      = flag_d & capture_en;
    assign pop       = avs_read & (avs_address == ADDR_DATA);
    assign wr_status = avs_write & (avs_address == ADDR_STATUS);
    assign wr_ctrl   = avs_write & (avs_address == ADDR_CTRL);
    assign flush     = wr_ctrl & avs_writedata[BIT_FLUSH];

    key_fifo #(.DEPTH(DEPTH)) u_fifo (
        .Clk       (Clk),
        .Rst       (Rst),
        .push      (push),
        .push_data (key_value),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .drop      (drop)
    );

    always_comb begin
        rd_word = '0;
        case (avs_address)
            ADDR_DATA: begin
                if (!empty) begin
                    rd_word[BIT_VALID]   = 1'b1;
                    rd_word[KEY_W-1:0]   = head;
                end
            end
            ADDR_STATUS: begin
                rd_word[CNT_W-1:0]    = count;
                rd_word[BIT_EMPTY]    = empty;
                rd_word[BIT_FULL]     = full;
                rd_word[BIT_OVERFLOW] = overflow;
            end
            ADDR_CTRL: begin
                rd_word[BIT_CAPTURE] = capture_en;
                rd_word[BIT_IRQ_EN]  = irq_en;
            end
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state        <= ST_RUN;
            flag_d       <= 1'b0;
            irq_en       <= 1'b0;
            overflow     <= 1'b0;
            avs_readdata <= '0;
            irq          <= 1'b0;
        end else begin
            flag_d <= key_flag;
            if (wr_ctrl) begin
                state  <= avs_writedata[BIT_CAPTURE] ? ST_RUN : ST_HOLD;
                irq_en <= avs_writedata[BIT_IRQ_EN];
            end
            // A new drop outranks a software clear in the same cycle.
            if (drop) begin
                overflow <= 1'b1;
            end else if (wr_status && avs_writedata[BIT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            if (avs_read) begin
                avs_readdata <= rd_word;
            end
            irq <= irq_en & (~empty | overflow);
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - directed self-checking bench for key_event_queue
module tb_key_event_queue;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        key_flag = 1'b0;
    logic [3:0]  key_value = 4'd0;
    logic [1:0]  avs_address = 2'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] rdv;

    key_event_queue dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .key_flag      (key_flag),
        .key_value     (key_value),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic key_pulse(input logic [3:0] v);
        key_flag  = 1'b1;
        key_value = v;
        tick();
        key_flag = 1'b0;
        tick();
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        avs_read    = 1'b1;
        avs_address = a;
        tick();
        avs_read = 1'b0;
        d = avs_readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        avs_write     = 1'b1;
        avs_address   = a;
        avs_writedata = d;
        tick();
        avs_write     = 1'b0;
        avs_writedata = 32'd0;
    endtask

    initial begin
        // Reset state
        tick(); tick();
        Rst = 1'b0;
        check("rst_readdata", avs_readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        rd(2'd1, rdv); check("rst_status", rdv, 32'h0001_0000);
        rd(2'd2, rdv); check("rst_ctrl", rdv, 32'h1);
        rd(2'd3, rdv); check("addr3_reads0", rdv, 32'h0);

        // Single event
        key_pulse(4'd5);
        rd(2'd1, rdv); check("single_status", rdv, 32'h0000_0001);
        rd(2'd0, rdv); check("single_data", rdv, 32'h105);
        rd(2'd1, rdv); check("single_status_after", rdv, 32'h0001_0000);
        rd(2'd0, rdv); check("empty_data", rdv, 32'h0);

        // Ordering and pointer wrap
        for (int i = 0; i < 6; i++) key_pulse(4'(i));
        for (int i = 0; i < 4; i++) begin
            rd(2'd0, rdv); check("order_a", rdv, 32'h100 | i);
        end
        for (int i = 6; i < 12; i++) key_pulse(4'(i));
        rd(2'd1, rdv); check("order_full", rdv, 32'h0002_0008);
        for (int i = 4; i < 12; i++) begin
            rd(2'd0, rdv); check("order_b", rdv, 32'h100 | i);
        end
        rd(2'd1, rdv); check("order_end", rdv, 32'h0001_0000);

        // Overflow
        for (int i = 1; i <= 9; i++) key_pulse(4'(i));
        rd(2'd1, rdv); check("ovf_status", rdv, 32'h0006_0008);
        check("ovf_irq_disabled", {31'd0, irq}, 32'h0);
        for (int i = 1; i <= 8; i++) begin
            rd(2'd0, rdv); check("ovf_data", rdv, 32'h100 | i);
        end
        rd(2'd1, rdv); check("ovf_drained", rdv, 32'h0005_0000);
        wr(2'd1, 32'h0004_0000);
        rd(2'd1, rdv); check("ovf_cleared", rdv, 32'h0001_0000);

        // Push and pop in the same cycle at full
        for (int i = 0; i < 8; i++) key_pulse(4'(i));
        key_flag  = 1'b1;
        key_value = 4'hC;
        tick();
        key_flag    = 1'b0;
        avs_read    = 1'b1;
        avs_address = 2'd0;
        tick();
        avs_read = 1'b0;
        check("pp_data", avs_readdata, 32'h100);
        rd(2'd1, rdv); check("pp_status", rdv, 32'h0002_0008);
        for (int i = 1; i < 8; i++) begin
            rd(2'd0, rdv); check("pp_drain", rdv, 32'h100 | i);
        end
        rd(2'd0, rdv); check("pp_last", rdv, 32'h10C);
        rd(2'd1, rdv); check("pp_empty", rdv, 32'h0001_0000);

        // IRQ
        wr(2'd2, 32'h3);
        check("irq_idle", {31'd0, irq}, 32'h0);
        key_flag  = 1'b1;
        key_value = 4'hF;
        tick();
        key_flag = 1'b0;
        tick();
        check("irq_lag", {31'd0, irq}, 32'h0);
        tick();
        check("irq_set", {31'd0, irq}, 32'h1);

        // Flush in the same cycle as a push
        key_flag  = 1'b1;
        key_value = 4'h3;
        tick();
        key_flag      = 1'b0;
        avs_write     = 1'b1;
        avs_address   = 2'd2;
        avs_writedata = 32'h7;
        tick();
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        rd(2'd1, rdv); check("flush_status", rdv, 32'h0001_0000);
        check("flush_irq", {31'd0, irq}, 32'h0);
        rd(2'd0, rdv); check("flush_data", rdv, 32'h0);
        rd(2'd2, rdv); check("flush_ctrl", rdv, 32'h3);

        // Hold: flags ignored
        wr(2'd2, 32'h0);
        for (int i = 0; i < 3; i++) key_pulse(4'hA);
        rd(2'd1, rdv); check("hold_status", rdv, 32'h0001_0000);
        rd(2'd2, rdv); check("hold_ctrl", rdv, 32'h0);

        // Reset with entries queued
        wr(2'd2, 32'h3);
        for (int i = 0; i < 4; i++) key_pulse(4'(i + 2));
        rd(2'd1, rdv); check("pre_rst_status", rdv, 32'h0000_0004);
        check("pre_rst_irq", {31'd0, irq}, 32'h1);
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("mid_rst_irq", {31'd0, irq}, 32'h0);
        check("mid_rst_readdata", avs_readdata, 32'h0);
        rd(2'd1, rdv); check("mid_rst_status", rdv, 32'h0001_0000);
        rd(2'd2, rdv); check("mid_rst_ctrl", rdv, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
